// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, MEM redirects, mult/div busy wait, debug freeze.
// Enables/flushes are combinational from inputs and FSM state; stall_cnt saturates at 0xFFFF.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dest,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        mem_redirect,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_FREEZE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      r_saved;
  state_t      w_state_nxt;
  state_t      w_saved_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic [15:0] r_stall_cnt;
  logic        w_hazard;

  always_comb begin
    w_hazard = ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_saved_nxt  = r_saved;
    w_cnt_nxt    = r_cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (debug || (r_state == ST_FREEZE)) begin
      // Freeze holds the counter; only the state to return to is remembered.
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      if (debug) begin
        w_state_nxt = ST_FREEZE;
        if (r_state != ST_FREEZE) begin
          w_saved_nxt = r_state;
        end
      end else begin
        w_state_nxt = r_saved;
      end
    end else if (mem_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      w_state_nxt  = ST_RUN;
      w_cnt_nxt    = 6'd0;
    end else if (r_state == ST_MD_WAIT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      w_cnt_nxt    = r_cnt - 6'd1;
      if (r_cnt <= 6'd1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 6'd0;
      end
    end else if (md_start && ex_valid) begin
      w_cnt_nxt   = md_is_div ? 6'd32 : 6'd4;
      w_state_nxt = ST_MD_WAIT;
    end else if (w_hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (!pc_en && (r_state != ST_FREEZE) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign md_busy   = (r_state == ST_MD_WAIT) || ((r_state == ST_FREEZE) && (r_saved == ST_MD_WAIT));
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed driver queues expected outputs per cycle, negedge monitor compares.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        debug;
  logic [4:0]  id_rs, id_rt, ex_dest;
  logic        id_uses_rs, id_uses_rt, ex_valid, ex_mem_read;
  logic        md_start, md_is_div, mem_redirect;
  logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  localparam logic [2:0] EN_ALL  = 3'b111;
  localparam logic [2:0] EN_NONE = 3'b000;
  localparam logic [2:0] EN_LU   = 3'b001;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_ALL  = 3'b111;
  localparam logic [2:0] FL_LU   = 3'b010;
  localparam logic [2:0] FL_EXM  = 3'b001;

  typedef struct packed {
    logic [2:0]  en;
    logic [2:0]  fl;
    logic        busy;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  string sb_n[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .debug(debug),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .md_start(md_start), .md_is_div(md_is_div), .mem_redirect(mem_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_busy(md_busy), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compares the current cycle's outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e = sb_q.pop_front();
      nm = sb_n.pop_front();
      a.en   = {pc_en, if_id_en, id_ex_en};
      a.fl   = {if_id_flush, id_ex_flush, ex_mem_flush};
      a.busy = md_busy;
      a.st   = state;
      a.cnt  = stall_cnt;
      n_chk++;
      if (a == e) begin
        n_pass++;
      end else begin
        $display("FAIL %s @%0t: got en=%b fl=%b busy=%b st=%0d cnt=%0d, want en=%b fl=%b busy=%b st=%0d cnt=%0d",
                 nm, $time, a.en, a.fl, a.busy, a.st, a.cnt, e.en, e.fl, e.busy, e.st, e.cnt);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [2:0] en, input logic [2:0] fl,
                          input logic busy, input logic [1:0] st, input int cnt);
    exp_t e;
    e.en   = en;
    e.fl   = fl;
    e.busy = busy;
    e.st   = st;
    e.cnt  = 16'(cnt);
    sb_q.push_back(e);
    sb_n.push_back(nm);
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cyc(input string nm, input logic [2:0] en, input logic [2:0] fl,
                     input logic busy, input logic [1:0] st, input int cnt);
    push_exp(nm, en, fl, busy, st, cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    debug = 0; id_rs = 0; id_rt = 0; ex_dest = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_valid = 0; ex_mem_read = 0; md_start = 0; md_is_div = 0; mem_redirect = 0;
  endtask

  task automatic set_lu(input logic [4:0] dest, input logic [4:0] rs);
    ex_valid = 1; ex_mem_read = 1; ex_dest = dest; id_rs = rs; id_uses_rs = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    reset = 1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_hold", EN_NONE, FL_ALL, 0, 0, 0);
    reset = 0;
    cyc("run_idle", EN_ALL, FL_NONE, 0, 0, 0);

    // Load-use on rs, then the same with r0, then on rt, then non-matching cases.
    set_lu(5'd5, 5'd5);
    cyc("lu_stall", EN_LU, FL_LU, 0, 0, 0);
    clr();
    cyc("lu_after", EN_ALL, FL_NONE, 0, 0, 1);
    set_lu(5'd0, 5'd0);
    cyc("lu_r0", EN_ALL, FL_NONE, 0, 0, 1);
    clr();
    ex_valid = 1; ex_mem_read = 1; ex_dest = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
    cyc("lu_rt", EN_LU, FL_LU, 0, 0, 1);
    id_uses_rt = 0;
    cyc("lu_rt_unused", EN_ALL, FL_NONE, 0, 0, 2);
    id_uses_rt = 1; ex_valid = 0;
    cyc("lu_ex_bubble", EN_ALL, FL_NONE, 0, 0, 2);
    clr();

    // Divide: 32 wait cycles; a second md_start mid-wait is ignored.
    ex_valid = 1; md_start = 1; md_is_div = 1;
    cyc("div_start", EN_ALL, FL_NONE, 0, 0, 2);
    clr();
    for (int i = 0; i < 32; i++) begin
      md_start = (i == 5); ex_valid = (i == 5);
      cyc("div_wait", EN_NONE, FL_EXM, 1, 1, 2 + i);
    end
    clr();
    cyc("div_done", EN_ALL, FL_NONE, 0, 0, 34);

    // Multiply aborted by a redirect on its 2nd wait cycle.
    ex_valid = 1; md_start = 1;
    cyc("mul_start", EN_ALL, FL_NONE, 0, 0, 34);
    clr();
    cyc("mul_wait1", EN_NONE, FL_EXM, 1, 1, 34);
    mem_redirect = 1;
    cyc("mul_redirect", EN_ALL, FL_ALL, 1, 1, 35);
    clr();
    cyc("mul_aborted", EN_ALL, FL_NONE, 0, 0, 35);
    cyc("mul_run", EN_ALL, FL_NONE, 0, 0, 35);

    // Full multiply: exactly 4 wait cycles.
    ex_valid = 1; md_start = 1;
    cyc("mul4_start", EN_ALL, FL_NONE, 0, 0, 35);
    clr();
    for (int i = 0; i < 4; i++) cyc("mul4_wait", EN_NONE, FL_EXM, 1, 1, 35 + i);
    cyc("mul4_done", EN_ALL, FL_NONE, 0, 0, 39);

    // Divide frozen on its 10th wait cycle for 7 debug cycles, then 23 more waits.
    ex_valid = 1; md_start = 1; md_is_div = 1;
    cyc("fz_start", EN_ALL, FL_NONE, 0, 0, 39);
    clr();
    for (int i = 0; i < 9; i++) cyc("fz_wait", EN_NONE, FL_EXM, 1, 1, 39 + i);
    debug = 1;
    cyc("fz_rise", EN_NONE, FL_NONE, 1, 1, 48);
    for (int i = 0; i < 6; i++) begin
      mem_redirect = (i == 2); md_start = (i == 3); ex_valid = (i == 3);
      cyc("fz_hold", EN_NONE, FL_NONE, 1, 2, 49);
    end
    clr();
    cyc("fz_exit", EN_NONE, FL_NONE, 1, 2, 49);
    for (int i = 0; i < 23; i++) cyc("fz_resume", EN_NONE, FL_EXM, 1, 1, 49 + i);
    cyc("fz_done", EN_ALL, FL_NONE, 0, 0, 72);

    // Simultaneous events.
    set_lu(5'd5, 5'd5); mem_redirect = 1;
    cyc("lu_plus_redirect", EN_ALL, FL_ALL, 0, 0, 72);
    clr();
    cyc("lu_redir_after", EN_ALL, FL_NONE, 0, 0, 72);
    debug = 1; mem_redirect = 1;
    cyc("debug_over_redir", EN_NONE, FL_NONE, 0, 0, 72);
    clr();
    cyc("freeze_from_run", EN_NONE, FL_NONE, 0, 2, 73);
    cyc("back_to_run", EN_ALL, FL_NONE, 0, 0, 73);

    // Asynchronous reset between edges while in MD_WAIT.
    ex_valid = 1; md_start = 1;
    cyc("rst_mul_start", EN_ALL, FL_NONE, 0, 0, 73);
    clr();
    cyc("rst_mul_wait", EN_NONE, FL_EXM, 1, 1, 73);
    #1;
    reset = 1;
    push_exp("async_reset", EN_NONE, FL_ALL, 0, 0, 0);
    #5;
    reset = 0;
    @(posedge clk);
    #1;
    cyc("post_reset", EN_ALL, FL_NONE, 0, 0, 0);
    cyc("post_reset2", EN_ALL, FL_NONE, 0, 0, 0);

    // Saturation: hold a load-use hazard continuously.
    set_lu(5'd9, 5'd9);
    repeat (65534) @(posedge clk);
    #1;
    cyc("sat_pre", EN_LU, FL_LU, 0, 0, 65534);
    cyc("sat_max", EN_LU, FL_LU, 0, 0, 65535);
    for (int i = 0; i < 3; i++) cyc("sat_hold", EN_LU, FL_LU, 0, 0, 65535);
    clr();
    cyc("sat_release", EN_ALL, FL_NONE, 0, 0, 65535);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 debug  in  1  freeze request while the instruction RAM is loaded externally.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 ex_valid  in  1  EX holds a real (non-bubble) instruction.
REQ-007 ex_mem_read  in  1  EX instruction is a load.
REQ-008 ex_dest  in  5  destination register of the EX instruction.
REQ-009 md_start  in  1  EX instruction is MULT/MULTU/DIV/DIVU, qualified by ex_valid.
REQ-010 md_is_div  in  1  with md_start: 1 = divide, 0 = multiply.
REQ-011 mem_redirect  in  1  MEM stage redirects PC (pc_init_control of MEM).
REQ-012 pc_en, if_id_en, id_ex_en  out  1 each  stage register load enables.
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  insert a bubble into the named register on the next edge.
REQ-014 md_busy  out  1  multiply/divide unit occupied.
REQ-015 state  out  2  FSM state: 0 RUN, 1 MD_WAIT, 2 FREEZE.
REQ-016 stall_cnt  out  16  count of stalled cycles.

Function
REQ-017 Priority per cycle SHALL be: reset > debug > mem_redirect > md_start / MD_WAIT > load-use hazard.
REQ-018 RUN with no event SHALL drive all enables 1 and all flushes 0.
REQ-019 A load-use hazard SHALL be ex_valid & ex_mem_read & ex_dest!=0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest)).
REQ-020 On a load-use hazard in RUN, the outputs SHALL be combinational in the same cycle: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1; the stall SHALL last exactly 1 cycle; the state SHALL stay RUN.
REQ-021 On mem_redirect (any state except FREEZE), the outputs SHALL be pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1 in that cycle.
REQ-022 mem_redirect in MD_WAIT SHALL abort the operation: next state RUN, counter cleared, md_busy=0 next cycle.
REQ-023 md_start in RUN SHALL load a 6-bit counter with 4 (multiply) or 32 (divide) and enter MD_WAIT at the next edge; that cycle behaves as normal RUN.
REQ-024 MD_WAIT SHALL drive pc_en=if_id_en=id_ex_en=0 and ex_mem_flush=1, with md_busy=1; the counter SHALL decrement once per cycle.
REQ-025 When MD_WAIT has counter==1, the FSM SHALL go to RUN at the next edge; the total MD_WAIT duration SHALL be exactly 4 or 32 cycles.
REQ-026 md_start while in MD_WAIT SHALL be ignored.
REQ-027 debug=1 SHALL enter FREEZE at the next edge from any state, saving the prior state and counter.
REQ-028 During FREEZE (including the cycle debug rises), all enables SHALL be 0, all flushes 0, and mem_redirect and md_start SHALL be ignored.
REQ-029 When debug falls, the FSM SHALL return to the saved state at the next edge with the counter unchanged; md_busy SHALL hold its saved value throughout FREEZE.
REQ-030 stall_cnt SHALL increment on each edge where pc_en=0 and state!=FREEZE, and SHALL saturate at 0xFFFF.

Reset
REQ-031 While reset=1: state=RUN, counter=0, saved state=RUN, stall_cnt=0, md_busy=0, all enables 0, all flushes 1.
REQ-032 Reset asserted during MD_WAIT or FREEZE SHALL abort immediately; after release the block SHALL resume in RUN with all enables 1 at the first cycle.

Verification
REQ-033 The bench SHALL cover the load-use hazard: ex_mem_read=1, ex_dest=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for that cycle only; stall_cnt=1. Repeating with ex_dest=0 -> no stall.
REQ-034 The bench SHALL cover a divide: md_start=1, md_is_div=1 -> state=1 and md_busy=1 for exactly 32 cycles, then RUN; stall_cnt=32.
REQ-035 The bench SHALL cover redirect abort: a multiply enters MD_WAIT, then mem_redirect=1 on the 2nd wait cycle -> all three flushes=1 that cycle; next cycle state=0, md_busy=0.
REQ-036 The bench SHALL cover freeze and resume: debug=1 on the 10th MD_WAIT cycle of a divide for 7 cycles -> state=2, enables 0, stall_cnt unchanged; after debug falls, 23 more MD_WAIT cycles follow.
REQ-037 The bench SHALL cover simultaneous events: a load-use hazard plus mem_redirect in one cycle -> redirect outputs only (pc_en=1, three flushes). Reset pulsed asynchronously between edges during MD_WAIT -> outputs change to reset values at once, state=0.
REQ-038 The bench SHALL cover saturation: stall_cnt preset near 0xFFFF through continued stalls -> stall_cnt holds at 0xFFFF.
